dsky_relay_decoder: RTL and testbench
=====================================

Name: dsky_relay_decoder

Overview:
- Receiving end of the AGC DSKY relay-word interface (channel 10 drive).
- Takes the AGC's RYWD12/13/14/16 row-address lines and RLYB01–RLYB11 relay-bit lines, emulating relay settling with a stability filter.
- Latches each settled word into a 12-row relay image and decodes rows 1–11 into BCD display digits and sign flags, and row 12 into indicator-light bits.
- Sits beside fpga_agc in the top level and feeds the display/monitor logic.

Parameters:
- STABLE_CYCLES, 16: consecutive CLOCK cycles a synchronised word must hold unchanged before commit (legal range 2–255).

Ports:
- CLOCK  input  1  B8 clock, 2.048 MHz; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rywd  input  4  {RYWD16,RYWD14,RYWD13,RYWD12}, row address, MSB first.
- rlyb  input  11  RLYB11..RLYB01.
- prog  output  8  {MD1,MD2} BCD.
- verb  output  8  {VD1,VD2} BCD.
- noun  output  8  {ND1,ND2} BCD.
- r1, r2, r3  output  20 each  {D1..D5} BCD per register.
- r1_sign, r2_sign, r3_sign  output  2 each  {plus,minus}.
- lights  output  11  row-12 relay bits 11..1.
- word_strobe  output  1  one-cycle pulse when a valid row commits.
- last_addr  output  4  address of last committed valid row.
- reject_count  output  8  count of committed words with address 13–15, saturating.

Behaviour:
- Reset values (asynchronous, immediate on rst_n low):
  - All BCD digits 4'hF (blank).
  - Signs, lights, word_strobe, last_addr and reject_count 0.
  - Synchronisers and the filter counter clear; FSM enters HELD with held word 0.
- Input path: 2-flop synchroniser on all 15 bits → w; w_prev registered each cycle.
- Stability filter:
  - cnt clears when w != w_prev.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
- FSM states:
  - HELD: a word is committed. If w != committed word → SETTLE.
  - SETTLE: filtering. When cnt reaches STABLE_CYCLES-1 with w == w_prev → COMMIT.
  - COMMIT: single cycle; performs the update below, then → HELD with the committed word = w.
- Commit actions by address:
  - Address 0: no output change, no strobe.
  - Addresses 13–15: reject_count +1 (saturates at 255); no other change, no strobe.
  - Addresses 1–12: update per the row map; last_addr = address; word_strobe = 1 for exactly one cycle.
  - Updated outputs become visible in the same cycle as word_strobe.
- Latency: input changes and then holds steady → outputs and word_strobe on edge STABLE_CYCLES+3 after the change.
- A steady word commits exactly once; re-committing requires a change to any other value, then a return.
- A change during SETTLE restarts the filter; a glitch shorter than STABLE_CYCLES produces no commit.
- Relay-bit fields: rlyb[10:6] = left code (L), rlyb[5:1] = right code (R), rlyb[11] = flag bit.
- Row map (address: flag, L, R):
  - 11: flag ignored, MD1, MD2.
  - 10: ignored, VD1, VD2.
  - 9: ignored, ND1, ND2.
  - 8: ignored, L ignored, R1D1.
  - 7: r1 plus, R1D2, R1D3.
  - 6: r1 minus, R1D4, R1D5.
  - 5: r2 plus, R2D1, R2D2.
  - 4: r2 minus, R2D3, R2D4.
  - 3: ignored, R2D5, R3D1.
  - 2: r3 plus, R3D2, R3D3.
  - 1: r3 minus, R3D4, R3D5.
  - 12: lights = rlyb[11:1].
- Code → BCD:
  - 0→21, 1→3, 2→25, 3→27, 4→15, 5→30, 6→28, 7→19, 8→29, 9→31 (relay codes in decimal).
  - Code 0 → 4'hF (blank).
  - Any other code → 4'hE (invalid); the row still commits.
- Digit outputs are decoded combinationally from the stored 5-bit codes, or stored pre-decoded; either way they hold their value between commits.
- Sign bits: plus and minus are stored independently; both may be 1.
- Reset mid-SETTLE discards the pending word; after release the current input is filtered afresh from HELD/0.

Test Plan:
- Reset: assert rst_n low mid-run → all digits 4'hF, signs/lights/strobe/last_addr/reject_count 0 immediately. Release, hold inputs 0 for 100 cycles → no strobe.
- Verb load: rywd=10, rlyb={0,11001,11101}, held steady → word_strobe single pulse 19 edges after the change (STABLE_CYCLES=16); verb=8'h28, last_addr=10; no further strobe over 200 cycles.
- Sign/blank/invalid: row 7 with rlyb={1,00000,01010} → r1_sign=2'b10, R1D2=4'hF, R1D3=4'hE. Then row 6 with flag=1 → r1_sign=2'b11.
- Glitch rejection: toggle rlyb[1] for 10 cycles, then restore the committed word → no strobe, outputs unchanged. A 16-cycle hold of a new row-9 word → commits.
- Reject/address 0: commit address 14 three times (alternating with address 0) → reject_count=3, no strobe, display unchanged. With reject_count preloaded to 255 by 255 commits → stays 255.
- Lights and back-to-back: row 12 with rlyb=11'h5A5, then immediately row 11 → lights=11'h5A5, then prog updated; two strobes separated by ≥19 cycles; reset during the second SETTLE → prog remains 8'hFF.

Source files
------------

// File: rtl/dsky_relay_decoder.sv
`default_nettype none
// ============================================================================
// dsky_relay_decoder : AGC channel-10 relay-word receiver, settle filter, DSKY decode
// Revision: 1.0
// ============================================================================
module dsky_relay_decoder #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        CLOCK,
  input  logic        rst_n,
  input  logic [3:0]  rywd,
  input  logic [10:0] rlyb,
  output logic [7:0]  prog,
  output logic [7:0]  verb,
  output logic [7:0]  noun,
  output logic [19:0] r1,
  output logic [19:0] r2,
  output logic [19:0] r3,
  output logic [1:0]  r1_sign,
  output logic [1:0]  r2_sign,
  output logic [1:0]  r3_sign,
  output logic [10:0] lights,
  output logic        word_strobe,
  output logic [3:0]  last_addr,
  output logic [7:0]  reject_count
);

  typedef enum logic [1:0] {HELD = 2'd0, SETTLE = 2'd1, COMMIT = 2'd2} state_t;

  localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  function automatic logic [3:0] relay_to_bcd(input logic [4:0] code);
    case (code)
      5'd0:    relay_to_bcd = 4'hF;
      5'd21:   relay_to_bcd = 4'd0;
      5'd3:    relay_to_bcd = 4'd1;
      5'd25:   relay_to_bcd = 4'd2;
      5'd27:   relay_to_bcd = 4'd3;
      5'd15:   relay_to_bcd = 4'd4;
      5'd30:   relay_to_bcd = 4'd5;
      5'd28:   relay_to_bcd = 4'd6;
      5'd19:   relay_to_bcd = 4'd7;
      5'd29:   relay_to_bcd = 4'd8;
      5'd31:   relay_to_bcd = 4'd9;
      default: relay_to_bcd = 4'hE;
    endcase
  endfunction

  logic [14:0] sync1_q, sync2_q, w_prev_q;
  logic [14:0] held_q, held_d;
  logic [7:0]  cnt_q, cnt_d;
  state_t      state_q, state_d;
  logic [7:0]  prog_q, prog_d, verb_q, verb_d, noun_q, noun_d;
  logic [19:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
  // {r1+, r1-, r2+, r2-, r3+, r3-}
  logic [5:0]  sign_q, sign_d;
  logic [10:0] lights_q, lights_d;
  logic        strobe_q, strobe_d;
  logic [3:0]  last_addr_q, last_addr_d;
  logic [7:0]  rej_q, rej_d;

  logic [14:0] w;
  logic [3:0]  w_addr;
  logic        w_flag;
  logic [3:0]  dig_l, dig_r;

  assign w      = sync2_q;
  assign w_addr = w[14:11];
  assign w_flag = w[10];
  assign dig_l  = relay_to_bcd(w[9:5]);
  assign dig_r  = relay_to_bcd(w[4:0]);

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      w_prev_q    <= '0;
      held_q      <= '0;
      cnt_q       <= '0;
      state_q     <= HELD;
      prog_q      <= 8'hFF;
      verb_q      <= 8'hFF;
      noun_q      <= 8'hFF;
      r1_q        <= 20'hFFFFF;
      r2_q        <= 20'hFFFFF;
      r3_q        <= 20'hFFFFF;
      sign_q      <= '0;
      lights_q    <= '0;
      strobe_q    <= 1'b0;
      last_addr_q <= '0;
      rej_q       <= '0;
    end else begin
      sync1_q     <= {rywd, rlyb};
      sync2_q     <= sync1_q;
      w_prev_q    <= sync2_q;
      held_q      <= held_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      prog_q      <= prog_d;
      verb_q      <= verb_d;
      noun_q      <= noun_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      r3_q        <= r3_d;
      sign_q      <= sign_d;
      lights_q    <= lights_d;
      strobe_q    <= strobe_d;
      last_addr_q <= last_addr_d;
      rej_q       <= rej_d;
    end
  end

  always_comb begin
    if (w != w_prev_q)        cnt_d = '0;
    else if (cnt_q >= CNT_MAX) cnt_d = CNT_MAX;
    else                      cnt_d = cnt_q + 8'd1;
  end

  // Output registers load on the SETTLE->COMMIT edge so the new display
  // values appear in the same cycle as word_strobe.
  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    prog_d      = prog_q;
    verb_d      = verb_q;
    noun_d      = noun_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    r3_d        = r3_q;
    sign_d      = sign_q;
    lights_d    = lights_q;
    strobe_d    = 1'b0;
    last_addr_d = last_addr_q;
    rej_d       = rej_q;

    case (state_q)
      HELD: begin
        if (w != held_q) state_d = SETTLE;
      end
      SETTLE: begin
        // Returning to the already-committed word is not a new commit.
        if (w == held_q) begin
          state_d = HELD;
        end else if ((w == w_prev_q) && (cnt_q >= CNT_LAST)) begin
          state_d = COMMIT;
          held_d  = w;
          case (w_addr)
            4'd0: ;
            4'd13, 4'd14, 4'd15: begin
              if (rej_q != 8'hFF) rej_d = rej_q + 8'd1;
            end
            default: begin
              last_addr_d = w_addr;
              strobe_d    = 1'b1;
              case (w_addr)
                4'd11: prog_d = {dig_l, dig_r};
                4'd10: verb_d = {dig_l, dig_r};
                4'd9:  noun_d = {dig_l, dig_r};
                4'd8:  r1_d[19:16] = dig_r;
                4'd7: begin
                  sign_d[5]   = w_flag;
                  r1_d[15:12] = dig_l;
                  r1_d[11:8]  = dig_r;
                end
                4'd6: begin
                  sign_d[4]  = w_flag;
                  r1_d[7:4]  = dig_l;
                  r1_d[3:0]  = dig_r;
                end
                4'd5: begin
                  sign_d[3]   = w_flag;
                  r2_d[19:16] = dig_l;
                  r2_d[15:12] = dig_r;
                end
                4'd4: begin
                  sign_d[2]  = w_flag;
                  r2_d[11:8] = dig_l;
                  r2_d[7:4]  = dig_r;
                end
                4'd3: begin
                  r2_d[3:0]   = dig_l;
                  r3_d[19:16] = dig_r;
                end
                4'd2: begin
                  sign_d[1]   = w_flag;
                  r3_d[15:12] = dig_l;
                  r3_d[11:8]  = dig_r;
                end
                4'd1: begin
                  sign_d[0] = w_flag;
                  r3_d[7:4] = dig_l;
                  r3_d[3:0] = dig_r;
                end
                4'd12:   lights_d = w[10:0];
                default: ;
              endcase
            end
          endcase
        end
      end
      COMMIT:  state_d = HELD;
      default: state_d = HELD;
    endcase
  end

  assign prog         = prog_q;
  assign verb         = verb_q;
  assign noun         = noun_q;
  assign r1           = r1_q;
  assign r2           = r2_q;
  assign r3           = r3_q;
  assign r1_sign      = sign_q[5:4];
  assign r2_sign      = sign_q[3:2];
  assign r3_sign      = sign_q[1:0];
  assign lights       = lights_q;
  assign word_strobe  = strobe_q;
  assign last_addr    = last_addr_q;
  assign reject_count = rej_q;

endmodule
`default_nettype wire

// File: tb/tb_dsky_relay_decoder.sv
`default_nettype none
// Scoreboard bench for dsky_relay_decoder: each committing word pushes the
// expected cycle and full output image; the strobe monitor pops and compares.
module tb_dsky_relay_decoder;

  localparam int STABLE = 16;
  localparam int LAT    = STABLE + 3;

  logic        CLOCK = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rywd  = '0;
  logic [10:0] rlyb  = '0;
  logic [7:0]  prog, verb, noun;
  logic [19:0] r1, r2, r3;
  logic [1:0]  r1_sign, r2_sign, r3_sign;
  logic [10:0] lights;
  logic        word_strobe;
  logic [3:0]  last_addr;
  logic [7:0]  reject_count;

  dsky_relay_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .CLOCK(CLOCK), .rst_n(rst_n), .rywd(rywd), .rlyb(rlyb),
    .prog(prog), .verb(verb), .noun(noun),
    .r1(r1), .r2(r2), .r3(r3),
    .r1_sign(r1_sign), .r2_sign(r2_sign), .r3_sign(r3_sign),
    .lights(lights), .word_strobe(word_strobe),
    .last_addr(last_addr), .reject_count(reject_count)
  );

  initial forever #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  int checks  = 0;
  int errors  = 0;
  int strobes = 0;

  typedef struct packed {
    int           at;
    logic [104:0] img;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  logic [3:0]  bcd_tab [32];
  int          l_idx [16];
  int          r_idx [16];
  int          s_idx [16];
  // digit order: MD1 MD2 VD1 VD2 ND1 ND2 R1D1..5 R2D1..5 R3D1..5
  logic [3:0]  m_dig [21];
  // r1+ r1- r2+ r2- r3+ r3-
  logic        m_sign [6];
  logic [10:0] m_lights;
  logic [3:0]  m_last;
  logic [7:0]  m_rej;
  logic [14:0] m_held;

  logic [104:0] act;
  assign act = {last_addr, prog, verb, noun, r1, r2, r3,
                r1_sign, r2_sign, r3_sign, lights};

  function automatic logic [104:0] model_img();
    logic [104:0] v;
    v = {101'd0, m_last};
    for (int i = 0; i < 21; i++) v = (v << 4) | {101'd0, m_dig[i]};
    for (int i = 0; i < 6; i++)  v = (v << 1) | {104'd0, m_sign[i]};
    v = (v << 11) | {94'd0, m_lights};
    return v;
  endfunction

  task automatic init_tables();
    for (int i = 0; i < 32; i++) bcd_tab[i] = 4'hE;
    bcd_tab[0]  = 4'hF; bcd_tab[21] = 4'd0; bcd_tab[3]  = 4'd1;
    bcd_tab[25] = 4'd2; bcd_tab[27] = 4'd3; bcd_tab[15] = 4'd4;
    bcd_tab[30] = 4'd5; bcd_tab[28] = 4'd6; bcd_tab[19] = 4'd7;
    bcd_tab[29] = 4'd8; bcd_tab[31] = 4'd9;
    for (int i = 0; i < 16; i++) begin
      l_idx[i] = -1; r_idx[i] = -1; s_idx[i] = -1;
    end
    l_idx[11] = 0;  r_idx[11] = 1;
    l_idx[10] = 2;  r_idx[10] = 3;
    l_idx[9]  = 4;  r_idx[9]  = 5;
                    r_idx[8]  = 6;
    l_idx[7]  = 7;  r_idx[7]  = 8;  s_idx[7] = 0;
    l_idx[6]  = 9;  r_idx[6]  = 10; s_idx[6] = 1;
    l_idx[5]  = 11; r_idx[5]  = 12; s_idx[5] = 2;
    l_idx[4]  = 13; r_idx[4]  = 14; s_idx[4] = 3;
    l_idx[3]  = 15; r_idx[3]  = 16;
    l_idx[2]  = 17; r_idx[2]  = 18; s_idx[2] = 4;
    l_idx[1]  = 19; r_idx[1]  = 20; s_idx[1] = 5;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 21; i++) m_dig[i] = 4'hF;
    for (int i = 0; i < 6; i++)  m_sign[i] = 1'b0;
    m_lights = '0; m_last = '0; m_rej = '0; m_held = '0;
    sb.delete();
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge CLOCK);
  endtask

  task automatic put(input logic [3:0] a, input logic [10:0] b);
    @(posedge CLOCK);
    #1;
    rywd = a;
    rlyb = b;
  endtask

  // Drive a word that the caller will hold long enough to commit.
  task automatic send(input logic [3:0] a, input logic [10:0] b);
    exp_t e;
    put(a, b);
    if ({a, b} != m_held) begin
      m_held = {a, b};
      if (a >= 4'd1 && a <= 4'd12) begin
        if (a == 4'd12) m_lights = b;
        else begin
          if (l_idx[a] >= 0) m_dig[l_idx[a]] = bcd_tab[b[9:5]];
          if (r_idx[a] >= 0) m_dig[r_idx[a]] = bcd_tab[b[4:0]];
          if (s_idx[a] >= 0) m_sign[s_idx[a]] = b[10];
        end
        m_last = a;
        e.at  = cyc + LAT;
        e.img = model_img();
        sb.push_back(e);
      end else if (a >= 4'd13 && m_rej != 8'hFF) begin
        m_rej = m_rej + 8'd1;
      end
    end
  endtask

  always @(negedge CLOCK) begin
    if (rst_n && word_strobe) begin
      strobes++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: strobe at cycle %0d, required none", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.at != cyc || act !== mon_e.img) begin
          errors++;
          $display("FAIL strobe_commit: cycle %0d image %h, required cycle %0d image %h",
                   cyc, act, mon_e.at, mon_e.img);
        end
      end
    end
  end

  task automatic test_reset();
    int s0;
    send(4'd3, 11'b0_10101_00011);
    hold(LAT + 3);
    @(posedge CLOCK);
    #2;
    rst_n = 1'b0;
    rywd  = '0;
    rlyb  = '0;
    #1;
    model_reset();
    checks++;
    if ({act, word_strobe, reject_count} !== {model_img(), 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_async: got %h/%b/%h, required %h/0/00",
               act, word_strobe, reject_count, model_img());
    end
    hold(3);
    #1;
    rst_n = 1'b1;
    s0 = strobes;
    hold(100);
    #1;
    checks++;
    if (strobes != s0 || act !== model_img()) begin
      errors++;
      $display("FAIL reset_idle: strobes %0d image %h, required %0d %h",
               strobes - s0, act, 0, model_img());
    end
  endtask

  task automatic test_verb();
    int s0;
    s0 = strobes;
    send(4'd10, 11'b0_11001_11101);
    hold(LAT + 2);
    #1;
    checks++;
    if (verb !== 8'h28 || last_addr !== 4'd10 || strobes != s0 + 1) begin
      errors++;
      $display("FAIL verb_load: verb %h addr %0d strobes %0d, required 28 10 1",
               verb, last_addr, strobes - s0);
    end
    hold(200);
    checks++;
    if (strobes != s0 + 1) begin
      errors++;
      $display("FAIL verb_single: strobes %0d, required 1", strobes - s0);
    end
  endtask

  task automatic test_sign_blank_invalid();
    send(4'd7, 11'b1_00000_01010);
    hold(LAT + 2);
    #1;
    checks++;
    if (r1_sign !== 2'b10 || r1[15:12] !== 4'hF || r1[11:8] !== 4'hE) begin
      errors++;
      $display("FAIL sign_plus: r1_sign %b d2 %h d3 %h, required 10 F E",
               r1_sign, r1[15:12], r1[11:8]);
    end
    send(4'd6, 11'b1_11101_00011);
    hold(LAT + 2);
    #1;
    checks++;
    if (r1_sign !== 2'b11 || r1[7:0] !== 8'h81) begin
      errors++;
      $display("FAIL sign_both: r1_sign %b d45 %h, required 11 81", r1_sign, r1[7:0]);
    end
  endtask

  task automatic test_glitch();
    int s0;
    logic [14:0] base;
    s0   = strobes;
    base = m_held;
    for (int i = 0; i < 10; i++)
      put(base[14:11], base[10:0] ^ ((i % 2 == 0) ? 11'd1 : 11'd0));
    put(base[14:11], base[10:0]);
    hold(40);
    #1;
    checks++;
    if (strobes != s0 || act !== model_img()) begin
      errors++;
      $display("FAIL glitch_reject: strobes %0d image %h, required 0 %h",
               strobes - s0, act, model_img());
    end
    send(4'd9, 11'b0_10101_01111);
    hold(LAT + 2);
    #1;
    checks++;
    if (noun !== 8'h04 || strobes != s0 + 1) begin
      errors++;
      $display("FAIL glitch_then_commit: noun %h strobes %0d, required 04 1",
               noun, strobes - s0);
    end
  endtask

  task automatic test_reject();
    int s0;
    logic [104:0] img0;
    s0   = strobes;
    img0 = model_img();
    for (int k = 0; k < 3; k++) begin
      send(4'd14, 11'h123);
      hold(22);
      send(4'd0, 11'h000);
      hold(22);
    end
    #1;
    checks++;
    if (reject_count !== 8'd3 || strobes != s0 || act !== img0) begin
      errors++;
      $display("FAIL reject_three: count %0d strobes %0d image %h, required 3 0 %h",
               reject_count, strobes - s0, act, img0);
    end
    for (int k = 0; k < 253; k++) begin
      send((k % 2 == 0) ? 4'd13 : 4'd15, 11'(k));
      hold(21);
    end
    #1;
    checks++;
    if (reject_count !== 8'd255 || strobes != s0) begin
      errors++;
      $display("FAIL reject_saturate: count %0d strobes %0d, required 255 0",
               reject_count, strobes - s0);
    end
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = strobes;
    send(4'd12, 11'h5A5);
    hold(LAT - 1);
    send(4'd11, 11'b0_00011_11111);
    hold(LAT + 3);
    #1;
    checks++;
    if (lights !== 11'h5A5 || prog !== 8'h19 || strobes != s0 + 2) begin
      errors++;
      $display("FAIL back_to_back: lights %h prog %h strobes %0d, required 5a5 19 2",
               lights, prog, strobes - s0);
    end
    send(4'd12, 11'h2AA);
    hold(LAT + 2);
    put(4'd11, 11'b0_11011_01111);
    hold(10);
    #2;
    rst_n = 1'b0;
    rywd  = '0;
    rlyb  = '0;
    #1;
    model_reset();
    checks++;
    if (prog !== 8'hFF || act !== model_img() || reject_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_settle: prog %h image %h rej %0d, required ff %h 0",
               prog, act, reject_count, model_img());
    end
    hold(3);
    #1;
    rst_n = 1'b1;
    s0 = strobes;
    hold(50);
    #1;
    checks++;
    if (prog !== 8'hFF || strobes != s0) begin
      errors++;
      $display("FAIL reset_discard: prog %h strobes %0d, required ff 0", prog, strobes - s0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    init_tables();
    model_reset();
    hold(3);
    #1;
    rst_n = 1'b1;
    hold(5);
    test_reset();
    test_verb();
    test_sign_blank_invalid();
    test_glitch();
    test_reject();
    test_back_to_back();
    hold(5);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
